// File: rtl/fft_pkg.sv
// Shared constants, types and the bit-reversal helper for the FFT output stage.
// The input core delivers bins in bit-reversed order, and bitrev() maps them back.
package fft_pkg;

  localparam int N_FFT     = 128;
  localparam int LOG2N     = 7;
  localparam int LANES     = 4;
  localparam int NBITS_OUT = 15;
  localparam int WORD_W    = LOG2N - 2;
  localparam int N_WORDS   = N_FFT / LANES;

  typedef logic [2*NBITS_OUT-1:0] cplx_t;
  typedef logic [LOG2N-1:0]       addr_t;
  typedef logic [WORD_W-1:0]      word_t;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } rd_state_e;

  // Reverses the low nbits of idx. Bits of idx at or above nbits are dropped.
  function automatic addr_t bitrev(input addr_t idx, input int nbits);
    addr_t r;
    r = '0;
    for (int i = 0; i < LOG2N; i++) begin
      if (i < nbits) r[nbits-1-i] = idx[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_out_reorder_if.sv
// Lane bus between the FFT core, the reorder stage and its consumer.
// Both sides have no back-pressure. i_enable/o_valid qualify the lanes in the
// cycle they are high, and the receiver must accept the data in that same cycle.
interface fft_out_reorder_if;
  import fft_pkg::*;

  cplx_t fftIn0_up;
  cplx_t fftIn0_down;
  cplx_t fftIn1_up;
  cplx_t fftIn1_down;
  logic  i_enable;

  cplx_t fftOut0;
  cplx_t fftOut1;
  cplx_t fftOut2;
  cplx_t fftOut3;
  logic  o_valid;
  logic  o_sof;

  modport slave (
    input  fftIn0_up, fftIn0_down, fftIn1_up, fftIn1_down, i_enable,
    output fftOut0, fftOut1, fftOut2, fftOut3, o_valid, o_sof
  );

  modport master (
    output fftIn0_up, fftIn0_down, fftIn1_up, fftIn1_down, i_enable,
    input  fftOut0, fftOut1, fftOut2, fftOut3, o_valid, o_sof
  );
endinterface

// File: rtl/fft_reorder_bank.sv
// One buffer of the ping-pong pair. It holds a full frame in flops, takes four
// scattered writes per clock, and reads four consecutive bins into a register.
module fft_reorder_bank
  import fft_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  addr_t [LANES-1:0]      wr_addr,
  input  cplx_t [LANES-1:0]      wr_data,
  input  logic                   rd_en,
  input  word_t                  rd_word,
  output cplx_t [LANES-1:0]      rd_data
);

  cplx_t mem [N_FFT];

  // Contents are left uninitialised. Each frame overwrites every bin before the frame is read.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < LANES; k++) mem[wr_addr[k]] <= wr_data[k];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      for (int k = 0; k < LANES; k++) rd_data[k] <= mem[{rd_word, 2'(k)}];
    end
  end

endmodule

// File: rtl/fft_out_reorder.sv
// Reorders bit-reversed FFT output frames into natural bin order, four bins per
// clock. The two banks alternate, so the next frame fills while the previous one drains.
module fft_out_reorder
  import fft_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  fft_out_reorder_if.slave  bus,
  output rd_state_e         dbg_state
);

  word_t             wr_cnt;
  logic              wr_bank;
  logic              frame_done;
  logic              done_bank;

  rd_state_e         state, state_n;
  word_t             rd_cnt, rd_cnt_n;
  logic              rd_bank, rd_bank_n;
  logic              drain;

  logic              out_sel;
  logic              valid_q;
  logic              sof_q;

  addr_t [LANES-1:0] wr_addr;
  cplx_t [LANES-1:0] wr_data;
  cplx_t [LANES-1:0] rd_data0;
  cplx_t [LANES-1:0] rd_data1;

  assign wr_data = {bus.fftIn1_down, bus.fftIn1_up, bus.fftIn0_down, bus.fftIn0_up};

  always_comb begin
    for (int k = 0; k < LANES; k++) wr_addr[k] = bitrev({wr_cnt, 2'(k)}, LOG2N);
  end

  // frame_done is registered. This adds the second cycle of latency before the drain starts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_cnt     <= '0;
      wr_bank    <= 1'b0;
      frame_done <= 1'b0;
      done_bank  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (bus.i_enable) begin
        wr_cnt <= wr_cnt + WORD_W'(1);
        if (wr_cnt == WORD_W'(N_WORDS-1)) begin
          wr_bank    <= ~wr_bank;
          frame_done <= 1'b1;
          done_bank  <= wr_bank;
        end
      end
    end
  end

  fft_reorder_bank u_bank0 (
    .clk     (clk),
    .rst     (rst),
    .we      (bus.i_enable && !wr_bank),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (drain && !rd_bank),
    .rd_word (rd_cnt),
    .rd_data (rd_data0)
  );

  fft_reorder_bank u_bank1 (
    .clk     (clk),
    .rst     (rst),
    .we      (bus.i_enable && wr_bank),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (drain && rd_bank),
    .rd_word (rd_cnt),
    .rd_data (rd_data1)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      rd_cnt  <= '0;
      rd_bank <= 1'b0;
    end else begin
      state   <= state_n;
      rd_cnt  <= rd_cnt_n;
      rd_bank <= rd_bank_n;
    end
  end

  // A frame can end on the last drain cycle. The drain then continues into the
  // other bank with no idle cycle.
  always_comb begin
    state_n   = state;
    rd_cnt_n  = rd_cnt;
    rd_bank_n = rd_bank;
    unique case (state)
      IDLE: begin
        if (frame_done) begin
          state_n   = DRAIN;
          rd_cnt_n  = '0;
          rd_bank_n = done_bank;
        end
      end
      DRAIN: begin
        rd_cnt_n = rd_cnt + WORD_W'(1);
        if (rd_cnt == WORD_W'(N_WORDS-1)) begin
          rd_cnt_n = '0;
          if (frame_done) rd_bank_n = done_bank;
          else            state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign drain     = (state == DRAIN);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      out_sel <= 1'b0;
    end else begin
      valid_q <= drain;
      sof_q   <= drain && (rd_cnt == '0);
      if (drain) out_sel <= rd_bank;
    end
  end

  assign bus.fftOut0 = out_sel ? rd_data1[0] : rd_data0[0];
  assign bus.fftOut1 = out_sel ? rd_data1[1] : rd_data0[1];
  assign bus.fftOut2 = out_sel ? rd_data1[2] : rd_data0[2];
  assign bus.fftOut3 = out_sel ? rd_data1[3] : rd_data0[3];
  assign bus.o_valid = valid_q;
  assign bus.o_sof   = sof_q;

endmodule

// File: tb/tb_fft_out_reorder.sv
// Bench for fft_out_reorder. Bit-reversed frames go in, and a scoreboard checks
// the natural-order words that come out.
module tb_fft_out_reorder;
  import fft_pkg::*;

  localparam int NB = 128;
  localparam int W  = 30;
  localparam int EW = 4*W + 1;

  logic      clk = 1'b0;
  logic      rst = 1'b0;
  rd_state_e dbg_state;
  int        cyc = 0;

  fft_out_reorder_if bus ();

  fft_out_reorder dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [EW-1:0] exp_q[$];
  int            sof_cyc_q[$];
  int            errors = 0;
  int            checks = 0;
  int            valid_cnt;
  int            run_len;
  int            max_run;
  int            first_out_cyc;
  int            last_in_cyc;
  logic [14:0]   ext [4] = '{15'h3FFF, 15'h4000, 15'h0000, 15'h7FFF};

  function automatic int tb_bitrev(input int x);
    int r = 0;
    for (int i = 0; i < 7; i++) r |= ((x >> i) & 1) << (6 - i);
    return r;
  endfunction

  // Scoreboard: every valid output word is popped and compared here.
  always @(negedge clk) begin
    logic [EW-1:0] obs;
    logic [EW-1:0] exp;
    if (rst && bus.o_valid === 1'b1) begin
      obs = {bus.o_sof, bus.fftOut3, bus.fftOut2, bus.fftOut1, bus.fftOut0};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output got=%h required=none", obs);
      end else begin
        exp = exp_q.pop_front();
        if (obs !== exp) begin
          errors++;
          $display("FAIL scoreboard_word got=%h required=%h", obs, exp);
        end
      end
      valid_cnt++;
      run_len++;
      if (run_len > max_run) max_run = run_len;
      if (first_out_cyc < 0) first_out_cyc = cyc;
      if (bus.o_sof) sof_cyc_q.push_back(cyc);
    end else begin
      run_len = 0;
    end
  end

  task automatic clear_stats();
    valid_cnt     = 0;
    run_len       = 0;
    max_run       = 0;
    first_out_cyc = -1;
    sof_cyc_q.delete();
  endtask

  task automatic idle_inputs();
    bus.i_enable    = 1'b0;
    bus.fftIn0_up   = '0;
    bus.fftIn0_down = '0;
    bus.fftIn1_up   = '0;
    bus.fftIn1_down = '0;
  endtask

  // mode 0: re=bin+128*tag, im=-re.  mode 1: random extreme re/im values.
  task automatic drive_frame(input int mode, input int tag, input bit gappy, input int ncyc);
    logic [W-1:0] fr [NB];
    logic [14:0]  re, im;
    for (int b = 0; b < NB; b++) begin
      if (mode == 0) begin
        re = 15'(b + 128*tag);
        im = ~re + 15'd1;
      end else begin
        re = ext[$urandom_range(0, 3)];
        im = ext[$urandom_range(0, 3)];
      end
      fr[b] = {re, im};
    end
    for (int t = 0; t < ncyc; t++) begin
      bus.fftIn0_up   = fr[tb_bitrev(4*t)];
      bus.fftIn0_down = fr[tb_bitrev(4*t+1)];
      bus.fftIn1_up   = fr[tb_bitrev(4*t+2)];
      bus.fftIn1_down = fr[tb_bitrev(4*t+3)];
      bus.i_enable    = 1'b1;
      @(posedge clk); #1;
      last_in_cyc = cyc;
      if (gappy) begin
        idle_inputs();
        @(posedge clk); #1;
      end
    end
    if (ncyc == NB/4) begin
      for (int u = 0; u < NB/4; u++)
        exp_q.push_back({(u == 0), fr[4*u+3], fr[4*u+2], fr[4*u+1], fr[4*u]});
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout left=%0d required=0", exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b required=0", bus.o_valid); end
    checks++; if (bus.o_sof !== 1'b0) begin errors++; $display("FAIL reset_sof got=%b required=0", bus.o_sof); end
    checks++; if (bus.fftOut0 !== '0 || bus.fftOut3 !== '0) begin errors++; $display("FAIL reset_data got=%h/%h required=0", bus.fftOut0, bus.fftOut3); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state got=%0d required=%0d", dbg_state, IDLE); end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_single_frame();
    clear_stats();
    drive_frame(0, 0, 1'b0, NB/4);
    idle_inputs();
    wait_drain(60);
    checks++; if (first_out_cyc !== last_in_cyc + 2) begin errors++; $display("FAIL single_latency got=%0d required=%0d", first_out_cyc, last_in_cyc + 2); end
    checks++; if (valid_cnt !== 32) begin errors++; $display("FAIL single_valid_count got=%0d required=32", valid_cnt); end
    checks++; if (max_run !== 32) begin errors++; $display("FAIL single_contiguous got=%0d required=32", max_run); end
    checks++; if (sof_cyc_q.size() !== 1) begin errors++; $display("FAIL single_sof_count got=%0d required=1", sof_cyc_q.size()); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL single_end_state got=%0d required=%0d", dbg_state, IDLE); end
  endtask

  task automatic test_back_to_back();
    clear_stats();
    for (int f = 1; f <= 3; f++) drive_frame(0, f, 1'b0, NB/4);
    idle_inputs();
    wait_drain(150);
    checks++; if (valid_cnt !== 96) begin errors++; $display("FAIL b2b_valid_count got=%0d required=96", valid_cnt); end
    checks++; if (max_run !== 96) begin errors++; $display("FAIL b2b_contiguous got=%0d required=96", max_run); end
    checks++; if (sof_cyc_q.size() !== 3) begin errors++; $display("FAIL b2b_sof_count got=%0d required=3", sof_cyc_q.size()); end
    for (int i = 1; i < sof_cyc_q.size(); i++) begin
      checks++;
      if (sof_cyc_q[i] - sof_cyc_q[i-1] !== 32) begin
        errors++;
        $display("FAIL b2b_sof_spacing got=%0d required=32", sof_cyc_q[i] - sof_cyc_q[i-1]);
      end
    end
  endtask

  task automatic test_gappy();
    clear_stats();
    drive_frame(0, 2, 1'b1, NB/4);
    checks++; if (valid_cnt !== 0) begin errors++; $display("FAIL gappy_early_valid got=%0d required=0", valid_cnt); end
    idle_inputs();
    wait_drain(60);
    checks++; if (first_out_cyc !== last_in_cyc + 2) begin errors++; $display("FAIL gappy_latency got=%0d required=%0d", first_out_cyc, last_in_cyc + 2); end
    checks++; if (max_run !== 32 || valid_cnt !== 32) begin errors++; $display("FAIL gappy_contiguous got=%0d/%0d required=32/32", max_run, valid_cnt); end
  endtask

  task automatic test_boundary();
    clear_stats();
    drive_frame(1, 0, 1'b0, NB/4);
    drive_frame(1, 0, 1'b0, NB/4);
    idle_inputs();
    wait_drain(100);
    checks++; if (valid_cnt !== 64) begin errors++; $display("FAIL boundary_valid_count got=%0d required=64", valid_cnt); end
  endtask

  task automatic test_swap();
    clear_stats();
    drive_frame(0, 1, 1'b0, NB/4);
    drive_frame(0, 3, 1'b0, NB/4);
    idle_inputs();
    wait_drain(100);
    checks++; if (max_run !== 64) begin errors++; $display("FAIL swap_contiguous got=%0d required=64", max_run); end
    checks++; if (sof_cyc_q.size() !== 2) begin errors++; $display("FAIL swap_sof_count got=%0d required=2", sof_cyc_q.size()); end
  endtask

  task automatic test_reset_mid();
    clear_stats();
    drive_frame(0, 0, 1'b0, NB/4);
    drive_frame(0, 1, 1'b0, 10);
    rst = 1'b0;
    #1;
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b required=0", bus.o_valid); end
    checks++; if (bus.fftOut1 !== '0 || bus.fftOut2 !== '0) begin errors++; $display("FAIL midrst_data got=%h/%h required=0", bus.fftOut1, bus.fftOut2); end
    checks++; if (valid_cnt < 1) begin errors++; $display("FAIL midrst_drain_started got=%0d required>=1", valid_cnt); end
    exp_q.delete();
    idle_inputs();
    @(posedge clk); #1;
    rst = 1'b1;
    clear_stats();
    repeat (6) @(posedge clk);
    #1;
    checks++; if (valid_cnt !== 0) begin errors++; $display("FAIL midrst_partial_emitted got=%0d required=0", valid_cnt); end
    drive_frame(0, 2, 1'b0, NB/4);
    idle_inputs();
    wait_drain(60);
    checks++; if (valid_cnt !== 32 || sof_cyc_q.size() !== 1) begin errors++; $display("FAIL midrst_new_frame got=%0d/%0d required=32/1", valid_cnt, sof_cyc_q.size()); end
    checks++; if (first_out_cyc !== last_in_cyc + 2) begin errors++; $display("FAIL midrst_latency got=%0d required=%0d", first_out_cyc, last_in_cyc + 2); end
  endtask

  initial begin
    clear_stats();
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_gappy();
    test_boundary();
    test_swap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

endmodule
